// File: rtl/pixmem_pkg.sv
// Shared definitions for the 4-bit pixel memory path: the write stage
// (pixel_pack_writer) and the read stage use the same row geometry.
//   DATA_WIDTH  : SRAM word width including the spare bit
//   ROW_WIDTH   : payload bits per row (DATA_WIDTH-1)
//   ADDR_WIDTH  : SRAM address width
//   PIX_PER_ROW : 4-bit pixels per row
//   CNT_WIDTH   : width of a job's pixel count
package pixmem_pkg;

  localparam int unsigned DATA_WIDTH  = 65;
  localparam int unsigned ROW_WIDTH   = DATA_WIDTH - 1;
  localparam int unsigned ADDR_WIDTH  = 11;
  localparam int unsigned PIX_WIDTH   = 4;
  localparam int unsigned PIX_PER_ROW = ROW_WIDTH / PIX_WIDTH;
  localparam int unsigned IDX_WIDTH   = $clog2(PIX_PER_ROW);
  localparam int unsigned BIT_IDX_W   = $clog2(ROW_WIDTH);
  localparam int unsigned CNT_WIDTH   = 16;

  typedef logic [ROW_WIDTH-1:0]  row_t;
  typedef logic [PIX_WIDTH-1:0]  pix_t;
  typedef logic [IDX_WIDTH-1:0]  nib_idx_t;
  typedef logic [ADDR_WIDTH-1:0] row_addr_t;

  // Writer job sequencing.
  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_RUN   = 2'd1,
    WR_DRAIN = 2'd2,
    WR_FIN   = 2'd3
  } wr_state_e;

  // One row waiting for (or in) an SRAM write.
  typedef struct packed {
    row_addr_t addr;
    row_t      data;
  } row_req_t;

  // Pixel k of a row lives at bits [4k+3:4k].
  function automatic pix_t nibble_get(row_t row, nib_idx_t idx);
    logic [BIT_IDX_W-1:0] lsb;
    lsb = {idx, 2'b00};
    return row[lsb +: PIX_WIDTH];
  endfunction

  function automatic row_t nibble_put(row_t row, nib_idx_t idx, pix_t pix);
    row_t                 r;
    logic [BIT_IDX_W-1:0] lsb;
    lsb = {idx, 2'b00};
    r = row;
    r[lsb +: PIX_WIDTH] = pix;
    return r;
  endfunction

endpackage

// File: rtl/nibble_packer.sv
// Pack buffer: collects 4-bit pixels into a row, nibble 0 first.
//   clock, rst   : clock, async active-high reset
//   clear_i      : restart with an empty row at nibble 0
//   wr_en_i      : write pix_i at the current nibble index
//   pix_i        : pixel value
//   last_i       : this write closes the row even if not full
//   row_c        : current row with pix_i merged in (handoff data)
//   row_done_c   : the write this cycle completes a row
//   idx_next_c   : nibble index after this cycle
// A completed row leaves on the same edge it completes; the buffer is
// then zero again, so a short final row is zero-padded for free.
module nibble_packer
  import pixmem_pkg::*;
(
  input  logic     clock,
  input  logic     rst,
  input  logic     clear_i,
  input  logic     wr_en_i,
  input  pix_t     pix_i,
  input  logic     last_i,
  output row_t     row_c,
  output logic     row_done_c,
  output nib_idx_t idx_next_c
);

  row_t     row_q, row_d;
  nib_idx_t idx_q, idx_d;

  // Merge, wrap and clear.
  always_comb begin
    row_d      = row_q;
    idx_d      = idx_q;
    row_c      = nibble_put(row_q, idx_q, pix_i);
    row_done_c = wr_en_i && ((idx_q == nib_idx_t'(PIX_PER_ROW - 1)) || last_i);
    if (clear_i || row_done_c) begin
      row_d = '0;
      idx_d = '0;
    end else if (wr_en_i) begin
      row_d = row_c;
      idx_d = idx_q + nib_idx_t'(1);
    end
    idx_next_c = idx_d;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      idx_q <= '0;
    end else begin
      row_q <= row_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/pixel_pack_writer.sv
// Write stage of the 4-bit pixel fetch path: packs 16 pixels per 64-bit
// row and writes consecutive rows to SRAM starting at base_addr.
//   clock, rst            : clock, async active-high reset
//   start                 : job start pulse (IDLE only)
//   base_addr, pixel_count: job parameters, latched on start
//   pix_valid/pix_data    : pixel stream in; pix_ready accepts
//   busy, done            : job status, done is a one-cycle pulse
//   data_ready_mem        : SRAM write acknowledge
//   csb, we, addr, din    : SRAM write port (csb/we active low)
// Build option PARTIAL_FLUSH_EN: write a zero-padded final partial row.
// Without it the job is truncated to whole rows.
module pixel_pack_writer
  import pixmem_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  pixel_count,
  input  logic                  pix_valid,
  input  logic [3:0]            pix_data,
  output logic                  pix_ready,
  output logic                  busy,
  output logic                  done,
  input  logic                  data_ready_mem,
  output logic                  csb,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-2:0] din
);

  wr_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] remain_q, remain_d;
  row_addr_t            fill_addr_q, fill_addr_d;
  row_req_t             hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic                 csb_q, csb_d;
  logic                 we_q, we_d;
  row_addr_t            addr_q, addr_d;
  row_t                 din_q, din_d;
  logic                 pix_ready_q, pix_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [CNT_WIDTH-1:0] eff_cnt;
  logic                 accept;
  logic                 last_pix;
  logic                 pack_last;
  logic                 wr_issue;
  logic                 wr_ack;
  logic                 near_full;
  row_t                 pack_row;
  logic                 pack_done;
  nib_idx_t             idx_next;

`ifdef PARTIAL_FLUSH_EN
  assign eff_cnt   = pixel_count;
  assign pack_last = last_pix;
`else
  assign eff_cnt   = pixel_count & ~CNT_WIDTH'(PIX_PER_ROW - 1);
  assign pack_last = 1'b0;
`endif

  assign accept   = (state_q == WR_RUN) && pix_valid && pix_ready_q;
  assign last_pix = accept && (remain_q == CNT_WIDTH'(1));
  // A write launches only from an idle port, which enforces the idle
  // cycle after every ack.
  assign wr_issue = csb_q && hold_vld_q;
  assign wr_ack   = !csb_q && data_ready_mem;

  nibble_packer u_packer (
    .clock      (clock),
    .rst        (rst),
    .clear_i    ((state_q == WR_IDLE) && start),
    .wr_en_i    (accept),
    .pix_i      (pix_t'(pix_data)),
    .last_i     (pack_last),
    .row_c      (pack_row),
    .row_done_c (pack_done),
    .idx_next_c (idx_next)
  );

  // Job sequencing, hold buffer, SRAM handshake and status outputs.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    fill_addr_d = fill_addr_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    csb_d       = csb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    din_d       = din_q;
    near_full   = 1'b0;

    case (state_q)
      WR_IDLE: begin
        if (start) begin
          fill_addr_d = base_addr;
          remain_d    = eff_cnt;
          state_d     = (eff_cnt == '0) ? WR_FIN : WR_RUN;
        end
      end
      WR_RUN: begin
        if (accept) begin
          remain_d = remain_q - CNT_WIDTH'(1);
        end
        if (last_pix) begin
          state_d = WR_DRAIN;
        end
      end
      // Only the final row can be outstanding here, so its ack ends the job.
      WR_DRAIN: begin
        if (wr_ack) begin
          state_d = WR_FIN;
        end
      end
      WR_FIN: begin
        state_d = WR_IDLE;
      end
      default: begin
        state_d = WR_IDLE;
      end
    endcase

    // Ack frees the hold; a handoff on the same edge refills it.
    if (wr_ack) begin
      hold_vld_d = 1'b0;
    end
    if (pack_done) begin
      hold_d.addr = fill_addr_q;
      hold_d.data = pack_row;
      hold_vld_d  = 1'b1;
      fill_addr_d = fill_addr_q + ADDR_WIDTH'(1);
    end

    if (wr_issue) begin
      csb_d  = 1'b0;
      we_d   = 1'b0;
      addr_d = hold_q.addr;
      din_d  = hold_q.data;
    end else if (wr_ack) begin
      csb_d = 1'b1;
      we_d  = 1'b1;
    end

    // Stall before the pixel that would complete a row while the hold is
    // still occupied.
    near_full = (idx_next == nib_idx_t'(PIX_PER_ROW - 1));
`ifdef PARTIAL_FLUSH_EN
    near_full = near_full || (remain_d == CNT_WIDTH'(1));
`endif
    pix_ready_d = (state_d == WR_RUN) && !(hold_vld_d && near_full);
    busy_d      = (state_d == WR_RUN) || (state_d == WR_DRAIN);
    done_d      = (state_d == WR_FIN);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= WR_IDLE;
      remain_q    <= '0;
      fill_addr_q <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      csb_q       <= 1'b1;
      we_q        <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      fill_addr_q <= fill_addr_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      csb_q       <= csb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pix_ready = pix_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign csb       = csb_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign din       = din_q;

endmodule

// File: tb/tb_pixel_pack_writer.sv
// Bench for pixel_pack_writer: directed jobs plus randomized jobs, every
// write compared against rows built from the job's pixel list.
module tb_pixel_pack_writer;
  import pixmem_pkg::*;

  logic                  clock = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  pixel_count;
  logic                  pix_valid;
  logic [3:0]            pix_data;
  logic                  pix_ready;
  logic                  busy;
  logic                  done;
  logic                  data_ready_mem;
  logic                  csb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-2:0] din;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef PARTIAL_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  pixel_pack_writer dut (
    .clock          (clock),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .pixel_count    (pixel_count),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .busy           (busy),
    .done           (done),
    .data_ready_mem (data_ready_mem),
    .csb            (csb),
    .we             (we),
    .addr           (addr),
    .din            (din)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One job: launch, feed pixels, answer writes, then compare with the model.
  task automatic run_job(input string tag, input int base, input int cnt, input int first,
                         input int ack_lo, input int ack_hi, input int vld_pct,
                         input bit spur, input int mid_start, output int max_out);
    logic [3:0]            pix_q[$];
    logic [3:0]            got_q[$];
    logic [63:0]           exp_din[$];
    logic [ADDR_WIDTH-1:0] exp_addr[$];
    logic [63:0]           row;
    int eff, rows, p, start_cyc, last_ack, wait_cnt, n_ack, outstanding;
    bit open, after_ack, finished;

    for (int i = 0; i < cnt; i++)
      pix_q.push_back((first < 0) ? 4'($urandom) : 4'(first + i));
    eff  = FLUSH ? cnt : (cnt / 16) * 16;
    rows = (eff + 15) / 16;
    for (int r = 0; r < rows; r++) begin
      row = '0;
      for (int k = 0; k < 16; k++)
        if (16 * r + k < eff) row = row | (64'(pix_q[16 * r + k]) << (4 * k));
      exp_din.push_back(row);
      exp_addr.push_back(ADDR_WIDTH'(base + r));
    end

    @(posedge clock); #1;
    start       = 1'b1;
    base_addr   = ADDR_WIDTH'(base);
    pixel_count = CNT_WIDTH'(cnt);
    start_cyc   = cyc;
    p = 0; n_ack = 0; wait_cnt = 0; last_ack = -100; max_out = 0;
    open = 1'b0; after_ack = 1'b0; finished = 1'b0;

    for (int t = 0; t < 4000 && !finished; t++) begin
      @(posedge clock); #1;
      start       = (mid_start > 0) && (t == mid_start);
      base_addr   = ADDR_WIDTH'($urandom);
      pixel_count = CNT_WIDTH'($urandom_range(200, 1));
      pix_valid   = (p < cnt) && (int'($urandom_range(99)) < vld_pct);
      pix_data    = pix_valid ? pix_q[p] : 4'($urandom);
      @(negedge clock);
      if (t == 0) chk({tag, ":busy_after_start"}, 64'(busy), 64'(eff != 0));
      if (pix_valid && pix_ready) begin
        got_q.push_back(pix_data);
        p++;
      end
      outstanding = got_q.size() - 16 * n_ack;
      if (outstanding > max_out) max_out = outstanding;
      if (after_ack) begin
        chk({tag, ":idle_after_ack"}, 64'(csb), 64'(1));
        after_ack = 1'b0;
      end else if (!csb) begin
        if (!open) begin
          open     = 1'b1;
          wait_cnt = int'($urandom_range(ack_hi, ack_lo));
          chk({tag, ":wr_addr_first"}, 64'(addr), 64'(exp_addr[n_ack]));
          chk({tag, ":wr_din_first"}, 64'(din), exp_din[n_ack]);
        end
        if (wait_cnt == 0) begin
          data_ready_mem = 1'b1;
          chk({tag, ":wr_we"}, 64'(we), 64'(0));
          chk({tag, ":wr_addr_ack"}, 64'(addr), 64'(exp_addr[n_ack]));
          chk({tag, ":wr_din_ack"}, 64'(din), exp_din[n_ack]);
          n_ack++;
          last_ack  = cyc;
          open      = 1'b0;
          after_ack = 1'b1;
        end else begin
          wait_cnt--;
          data_ready_mem = 1'b0;
        end
      end else begin
        if (open) chk({tag, ":csb_dropped_early"}, 64'(csb), 64'(0));
        data_ready_mem = spur && ($urandom_range(3) == 0);
      end
      if (done) begin
        finished = 1'b1;
        chk({tag, ":done_busy"}, 64'(busy), 64'(0));
        chk({tag, ":done_latency"}, 64'(cyc), 64'((eff == 0) ? start_cyc + 1 : last_ack + 1));
      end
    end
    if (!finished) chk({tag, ":done_timeout"}, 64'(done), 64'(1));

    @(posedge clock); #1;
    start = 1'b0; pix_valid = 1'b0; data_ready_mem = 1'b0;
    @(negedge clock);
    chk({tag, ":done_pulse"}, 64'(done), 64'(0));
    chk({tag, ":idle_csb"}, 64'(csb), 64'(1));
    chk({tag, ":writes"}, 64'(n_ack), 64'(rows));
    chk({tag, ":accepted"}, 64'(got_q.size()), 64'(eff));
    for (int i = 0; i < got_q.size() && i < eff; i++)
      chk({tag, ":pixel_order"}, 64'(got_q[i]), 64'(pix_q[i]));
    chk({tag, ":outstanding_bound"}, 64'(max_out <= 31), 64'(1));
  endtask

  initial begin
    int mo;
    rst = 1'b1; start = 1'b0; base_addr = '0; pixel_count = '0;
    pix_valid = 1'b0; pix_data = '0; data_ready_mem = 1'b0;
    #1;
    chk("reset:csb", 64'(csb), 64'(1));
    chk("reset:we", 64'(we), 64'(1));
    chk("reset:addr", 64'(addr), 64'(0));
    chk("reset:din", 64'(din), 64'(0));
    chk("reset:pix_ready", 64'(pix_ready), 64'(0));
    chk("reset:busy_done", 64'({busy, done}), 64'(0));
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;

    run_job("t1_single_row", 48, 16, 0, 3, 3, 100, 1'b0, 0, mo);
    run_job("t2_backpressure", 48, 48, -1, 20, 20, 100, 1'b0, 0, mo);
    chk("t2_backpressure:peak_outstanding", 64'(mo), 64'(31));
    run_job("t3_partial", 100, 20, 1, 1, 2, 100, 1'b0, 0, mo);
    run_job("t4_empty", 7, 0, -1, 0, 0, 100, 1'b0, 0, mo);
    run_job("t4_short", 9, 7, -1, 0, 2, 100, 1'b0, 0, mo);

    // Reset while a write is waiting for its ack.
    @(posedge clock); #1;
    start = 1'b1; base_addr = ADDR_WIDTH'(300); pixel_count = CNT_WIDTH'(16);
    @(posedge clock); #1;
    start = 1'b0; pix_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      pix_data = 4'($urandom);
      @(negedge clock);
      if (!csb) break;
      @(posedge clock); #1;
    end
    chk("t5_reset:write_pending", 64'(csb), 64'(0));
    rst = 1'b1;
    #1;
    chk("t5_reset:csb", 64'(csb), 64'(1));
    chk("t5_reset:we", 64'(we), 64'(1));
    chk("t5_reset:busy", 64'(busy), 64'(0));
    chk("t5_reset:pix_ready", 64'(pix_ready), 64'(0));
    pix_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    run_job("t5_after_reset", 500, 16, -1, 0, 3, 100, 1'b0, 0, mo);

    run_job("t6_addr_wrap", 2047, 32, -1, 0, 4, 80, 1'b1, 5, mo);

    for (int j = 0; j < 8; j++)
      run_job("rand_job", int'($urandom_range(2047)), int'($urandom_range(80, 1)), -1,
              0, 5, int'($urandom_range(100, 30)), 1'b1, 3, mo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
